// File: rtl/alu_result_tx.sv
// alu_result_tx: UART-style serial transmitter for the ALU {sel, result} byte.
// One byte per valid/ready handshake, sent LSB first at CLKS_PER_BIT clocks
// per bit: start(0), 8 data bits, optional even parity, stop(1).
// Optional feature macro: PARITY_EN (adds an even-parity bit after bit 7).
module alu_result_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] result_in,
  input  logic [1:0] sel_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            bit_end;
  logic            accept;

  assign bit_end = (baud_q == BAUD_LAST);
  assign accept  = valid_in && ready_q;

  // Next-state, baud/bit counting and handshake capture
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (accept) begin
          shift_d = {sel_in, result_in};
          state_d = START;
          ready_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        ready_d = 1'b1;
      end
    endcase
    busy_d = ~ready_d;
  end

  // Line level follows the current state, so tx lags the state by one clock
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[bit_q];
`ifdef PARITY_EN
      PARITY:  tx_d = ^shift_q;
`endif
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers; reset abandons any frame and idles the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ready_out = ready_q;
  assign tx        = tx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Testbench for alu_result_tx: two instances (CLKS_PER_BIT 4 and 2) driven
// with directed and random words; a scoreboard queue holds accepted words and
// a negedge monitor compares tx/ready_out/busy against a frame-level model.
module tb_alu_result_tx;

  localparam int CPB0 = 4;
  localparam int CPB1 = 2;
`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    int         lane;
    logic [7:0] word;
    longint     acc;
  } sb_t;

  logic             clk;
  logic             rst_n;
  logic [1:0][5:0]  res_w;
  logic [1:0][1:0]  sel_w;
  logic [1:0]       vld;
  logic [1:0]       ready_w;
  logic [1:0]       tx_w;
  logic [1:0]       busy_w;

  longint  cyc;
  longint  last_acc [2];
  sb_t     sb [$];
  int      checks;
  int      errors;
  int      frames_done;
  bit      mon_en;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_result_tx #(.CLKS_PER_BIT(g == 0 ? CPB0 : CPB1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .result_in (res_w[g]),
      .sel_in    (sel_w[g]),
      .valid_in  (vld[g]),
      .ready_out (ready_w[g]),
      .tx        (tx_w[g]),
      .busy      (busy_w[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint cpb(input int g);
    return (g == 0) ? longint'(CPB0) : longint'(CPB1);
  endfunction

  function automatic longint flen(input int g);
    return longint'(NB) * cpb(g);
  endfunction

  // Frame bit idx: 0 start, 1..8 data LSB first, then parity (if any), stop
  function automatic logic exp_bit(input logic [7:0] w, input longint idx);
    logic r;
    r = 1'b1;
    if (idx == 0) r = 1'b0;
    else if (idx >= 1 && idx <= 8) r = w[idx-1];
`ifdef PARITY_EN
    else if (idx == 9) begin
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(w[i]);
      r = (ones % 2 == 1);
    end
`endif
    return r;
  endfunction

  function automatic logic model_ready(input int g);
    return !(last_acc[g] <= cyc && cyc < last_acc[g] + flen(g));
  endfunction

  task automatic chk(input string name, input int g, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s lane=%0d cyc=%0d got=%0b exp=%0b", name, g, cyc, got, exp);
    end
  endtask

  // Called right after a negedge: sets inputs and records an accept if the
  // model says the transmitter is idle at the coming edge
  task automatic drive(input int g, input bit v, input logic [7:0] w);
    vld[g]   = v;
    sel_w[g] = w[7:6];
    res_w[g] = w[5:0];
    if (v && model_ready(g)) begin
      sb.push_back('{lane: g, word: w, acc: cyc + 1});
      last_acc[g] = cyc + 1;
    end
  endtask

  task automatic cycle2(input bit v0, input logic [7:0] w0, input bit v1, input logic [7:0] w1);
    @(negedge clk);
    drive(0, v0, w0);
    drive(1, v1, w1);
  endtask

  // Monitor: expected line level comes from whichever accepted word is in flight
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      for (int g = 0; g < 2; g++) begin
        logic   etx;
        logic   erdy;
        longint off;
        etx = 1'b1;
        foreach (sb[i]) begin
          if (sb[i].lane == g) begin
            off = cyc - sb[i].acc - 1;
            if (off >= 0 && off < flen(g)) etx = exp_bit(sb[i].word, off / cpb(g));
          end
        end
        erdy = model_ready(g);
        chk("tx", g, tx_w[g], etx);
        chk("ready_out", g, ready_w[g], erdy);
        chk("busy", g, busy_w[g], ~erdy);
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].lane == g && (cyc - sb[i].acc - 1) >= flen(g) - 1) begin
            sb.delete(i);
            frames_done++;
          end
        end
      end
    end
  end

  initial begin
    cyc         = 0;
    checks      = 0;
    errors      = 0;
    frames_done = 0;
    mon_en      = 1'b0;
    last_acc[0] = -1000;
    last_acc[1] = -1000;
    vld         = '0;
    res_w       = '0;
    sel_w       = '0;
    rst_n       = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("reset_tx", g, tx_w[g], 1'b1);
      chk("reset_ready", g, ready_w[g], 1'b1);
      chk("reset_busy", g, busy_w[g], 1'b0);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) cycle2(1'b0, 8'h00, 1'b0, 8'h00);

    // Single frame: sel=10, result=101101 -> 0xAD; lane1 sends 0xFF
    cycle2(1'b1, 8'hAD, 1'b1, 8'hFF);
    repeat (50) cycle2(1'b0, 8'($urandom), 1'b0, 8'($urandom));

    // Valid held high with data changing every cycle: stall and capture
    repeat (150) cycle2(1'b1, 8'($urandom), 1'b1, 8'($urandom));
    repeat (50) cycle2(1'b0, 8'($urandom), 1'b0, 8'($urandom));

    // Random valid pattern
    repeat (400) cycle2(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
    repeat (50) cycle2(1'b0, 8'h00, 1'b0, 8'h00);

    // Reset in the middle of DATA on lane0 (all-zero word keeps tx low there)
    cycle2(1'b1, 8'h00, 1'b0, 8'h00);
    repeat (8) cycle2(1'b0, 8'h00, 1'b0, 8'h00);
    #2;
    chk("pre_reset_tx_low", 0, tx_w[0], 1'b0);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("midframe_reset_tx", g, tx_w[g], 1'b1);
      chk("midframe_reset_ready", g, ready_w[g], 1'b1);
      chk("midframe_reset_busy", g, busy_w[g], 1'b0);
    end
    sb.delete();
    last_acc[0] = -1000;
    last_acc[1] = -1000;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (60) cycle2(1'b0, 8'($urandom), 1'b0, 8'($urandom));

    // One more frame after reset to show normal operation resumes
    cycle2(1'b1, 8'h5A, 1'b1, 8'hFF);
    repeat (60) cycle2(1'b0, 8'h00, 1'b0, 8'h00);

    chk("scoreboard_empty", -1, 1'(sb.size() == 0), 1'b1);
    chk("frames_seen", -1, 1'(frames_done >= 10), 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
